instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Writer side of the CPU instruction-memory interface. The CPU only reads instruction memory.
//  This block fills it at run time from a byte stream (valid/ready) instead of a hex file.
//  Holds the CPU in reset while loading and releases it when the image is complete.
//  Sits between the host byte link and the instruction-memory write port.
// PARAMETERS
//  ADDR_W      12       instruction-memory address width (depth = 2**ADDR_W words)
//  DATA_W      16       instruction word width; fixed at 16 (two bytes per word)
//  START_ADDR  12'h000  address of the first loaded word
// PORTS
//  clock        in   1       system clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  in_data      in   8       stream byte
//  in_valid     in   1       in_data valid
//  in_ready     out  1       loader accepts byte; transfer = in_valid & in_ready on rising clock
//  imem_we      out  1       instruction-memory write strobe, one cycle per word
//  imem_addr    out  ADDR_W  write address
//  imem_wdata   out  16      write data
//  cpu_hold     out  1       1 = CPU held (PC frozen at 0); 0 = CPU runs
//  load_done    out  1       level; image loaded successfully
//  load_err     out  1       level; header or checksum fault
//  words_loaded out  ADDR_W+1  count of words written so far
// BEHAVIOUR
//  Reset: state=CNT_HI, in_ready=1, imem_we=0, imem_addr=START_ADDR, imem_wdata=0,
//   cpu_hold=1, load_done=0, load_err=0, words_loaded=0.
//  Frame: CNT_HI, CNT_LO (16-bit word count N, big-endian), then N x {HI, LO} data bytes.
//  FSM: CNT_HI -> CNT_LO -> (N==0 ? DONE : N>2**ADDR_W ? ERR : DAT_HI).
//   DAT_HI -> DAT_LO -> (last word ? DONE/CHK : DAT_HI).
//  The FSM advances only on a transfer. in_valid without in_ready is ignored. Bubbles are allowed anywhere.
//  Write: the cycle after the LO byte transfer, imem_we=1 for exactly one cycle.
//   imem_wdata={HI,LO} and imem_addr=START_ADDR+index. words_loaded increments in the same cycle.
//  Address arithmetic is modulo 2**ADDR_W; START_ADDR+index wraps to 0.
//  in_ready=1 in CNT_HI/CNT_LO/DAT_HI/DAT_LO/CHK and 0 in DONE/ERR. Back-to-back bytes are accepted every cycle.
//  DONE: registered. cpu_hold falls and load_done rises in the cycle after the final imem_we.
//   With N==0, this happens one cycle after the CNT_LO transfer.
//  ERR: load_err=1, cpu_hold stays 1, no further writes. Only reset leaves DONE or ERR.
//  Reset mid-frame: the partial image stays in memory; the loader restarts at CNT_HI.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: one extra byte follows the data (state CHK).
//   It must equal the XOR of all count and data bytes.
//   Match -> DONE. Mismatch -> ERR (words already written remain).
//  Undefined: there is no CHK state, and DONE follows the last word directly.
// STRUCTURE
//  Package loader_pkg: state encoding (CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK, DONE, ERR)
//   and constant HDR_BYTES=2.
//  Single module; no sub-module. A byte-to-word assembler is too thin to split out.
// TESTING
//  1. Bytes 00 02 | 12 34 | AB CD, no gaps -> writes 1234@000 and ABCD@001.
//     Then load_done=1, cpu_hold=0, words_loaded=2.
//  2. Same frame with random in_valid gaps -> identical writes.
//     Never two imem_we within 2 cycles of the same byte.
//  3. Header 00 00 -> no imem_we; load_done=1 the cycle after the 2nd byte; in_ready=0 afterwards.
//  4. Header 10 01 (N=4097, ADDR_W=12) -> load_err=1, cpu_hold=1, no writes, in_ready=0.
//  5. Reset_n low after 3 of 6 bytes, then the full 6-byte frame
//     -> loader restarts at CNT_HI; final memory matches test 1.
//  6. LOADER_CHECKSUM_EN: frame 00 01 | 5A A5 | chk FE -> done.
//     chk 00 -> load_err=1; word 5AA5 is still written at 000.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and frame constants.
package loader_pkg;

   typedef enum logic [2:0] {
      CNT_HI,
      CNT_LO,
      DAT_HI,
      DAT_LO,
      CHK,
      DONE,
      ERR
   } state_t;

   localparam int unsigned HDR_BYTES = 2;

endpackage

// File: rtl/instr_loader.sv
// Fills instruction memory from a byte stream framed as {N_hi, N_lo, N x {hi, lo}} and holds the CPU until done.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_loader
   import loader_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 12,
   parameter int unsigned       DATA_W     = 16,
   parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   state_t            state, state_nx;
   logic [7:0]        cnt_hi;
   logic [7:0]        hi_byte;
   logic [ADDR_W:0]   remaining;
   logic [15:0]       n_words;
   logic              xfer;
   logic              last_word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        chk;
`endif

   assign n_words   = {cnt_hi, in_data};
   assign xfer      = in_valid & in_ready;
   assign last_word = (remaining == (ADDR_W+1)'(1));
   assign in_ready  = (state != DONE) && (state != ERR);
   assign load_err  = (state == ERR);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= CNT_HI;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (xfer) begin
         case (state)
            CNT_HI: state_nx = CNT_LO;
            CNT_LO: begin
               if (n_words == 16'h0)             state_nx = DONE;
               else if (32'(n_words) > DEPTH)    state_nx = ERR;
               else                              state_nx = DAT_HI;
            end
            DAT_HI: state_nx = DAT_LO;
            DAT_LO: begin
`ifdef LOADER_CHECKSUM_EN
               state_nx = last_word ? CHK : DAT_HI;
`else
               state_nx = last_word ? DONE : DAT_HI;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHK:    state_nx = (in_data == chk) ? DONE : ERR;
`endif
            default: state_nx = state;
         endcase
      end
   end

   // load_done waits one cycle past the final write so the CPU never fetches a word still being stored.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_hi       <= '0;
         hi_byte      <= '0;
         remaining    <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= START_ADDR;
         imem_wdata   <= '0;
         words_loaded <= '0;
         load_done    <= 1'b0;
         cpu_hold     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         chk          <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         if (imem_we && state == DONE) begin
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
         end
         if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            if (state != CHK) chk <= chk ^ in_data;
`endif
            case (state)
               CNT_HI: cnt_hi <= in_data;
               CNT_LO: begin
                  remaining <= (ADDR_W+1)'(n_words);
                  if (n_words == 16'h0) begin
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end
               end
               DAT_HI: hi_byte <= in_data;
               DAT_LO: begin
                  imem_we      <= 1'b1;
                  imem_wdata   <= DATA_W'({hi_byte, in_data});
                  imem_addr    <= START_ADDR + words_loaded[ADDR_W-1:0];
                  words_loaded <= words_loaded + 1'b1;
                  remaining    <= remaining - 1'b1;
               end
`ifdef LOADER_CHECKSUM_EN
               CHK: begin
                  if (in_data == chk) begin
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader; frames are checked against a byte-list model.
// Checksum frames are exercised when LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;
   import loader_pkg::*;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DEPTH  = 2**ADDR_W;

   typedef logic [7:0] byte_q_t[$];

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic [7:0]        in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   instr_loader #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (16),
      .START_ADDR (12'h000)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int          cyc   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clock) cyc = cyc + 1;

   // Write monitor and memory image
   logic [31:0] wq[$];
   logic [15:0] mem [DEPTH];
   int          prev_we_cyc = -10;
   int          last_we_cyc = -1;
   int          done_cyc    = -1;
   int unsigned close_we    = 0;
   logic        done_q      = 1'b0;

   always @(negedge clock) begin
      if (!reset_n) begin
         wq.delete();
         prev_we_cyc = -10;
         last_we_cyc = -1;
         done_cyc    = -1;
         close_we    = 0;
         done_q      = 1'b0;
      end else begin
         if (imem_we) begin
            wq.push_back({4'h0, imem_addr, imem_wdata});
            mem[imem_addr] = imem_wdata;
            if (cyc - prev_we_cyc < 2) close_we++;
            prev_we_cyc = cyc;
            last_we_cyc = cyc;
         end
         if (load_done && !done_q) done_cyc = cyc;
         done_q = load_done;
      end
   end

   function automatic byte_q_t add_chk(input byte_q_t q, input bit bad);
      byte_q_t    r = q;
      logic [7:0] x = '0;
`ifdef LOADER_CHECKSUM_EN
      if ({q[0], q[1]} != 16'h0) begin
         foreach (q[i]) x ^= q[i];
         r.push_back(bad ? ~x : x);
      end
`else
      if (bad) x = '0;
`endif
      return r;
   endfunction

   function automatic byte_q_t mk_frame(input int unsigned n, input bit bad);
      byte_q_t q;
      logic [15:0] n16 = 16'(n);
      q.push_back(n16[15:8]);
      q.push_back(n16[7:0]);
      for (int unsigned i = 0; i < 2*n; i++) q.push_back(8'($urandom));
      return add_chk(q, bad);
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_we", 32'(imem_we), 0);
      check("rst_addr", 32'(imem_addr), 0);
      check("rst_wdata", 32'(imem_wdata), 0);
      check("rst_hold", 32'(cpu_hold), 1);
      check("rst_done", 32'(load_done), 0);
      check("rst_err", 32'(load_err), 0);
      check("rst_words", 32'(words_loaded), 0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic send(input byte_q_t b, input int unsigned gap_pct, output int last_edge);
      int unsigned i = 0;
      int unsigned guard = 0;
      last_edge = -1;
      while (i < b.size() && guard < 200*b.size() + 200) begin
         @(negedge clock);
         if ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = b[i];
         end
         if (in_valid && in_ready) begin
            last_edge = cyc + 1;
            i++;
         end
         @(posedge clock);
         guard++;
      end
      @(negedge clock);
      in_valid = 1'b0;
      if (i != b.size()) check("send_stall", i, b.size());
   endtask

   task automatic run_frame(input string name, input byte_q_t b, input int unsigned gap_pct);
      int          last_edge;
      int unsigned n;
      int unsigned exp_wr;
      bit          exp_err;
      logic [7:0]  x;
      do_reset();
      send(b, gap_pct, last_edge);
      for (int t = 0; t < 40 && !(load_done || load_err); t++) @(negedge clock);
      check({name, "_end"}, 32'(load_done | load_err), 1);

      n       = {b[0], b[1]};
      exp_err = (n > DEPTH);
      exp_wr  = exp_err ? 0 : n;
`ifdef LOADER_CHECKSUM_EN
      if (!exp_err && n != 0) begin
         x = '0;
         for (int unsigned i = 0; i < HDR_BYTES + 2*n; i++) x ^= b[i];
         if (b[HDR_BYTES + 2*n] != x) exp_err = 1'b1;
      end
`else
      x = '0;
`endif

      // Stray bytes after completion must be refused
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         in_valid = 1'b1;
         in_data  = 8'($urandom);
      end
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);

      check({name, "_nwr"}, wq.size(), exp_wr);
      for (int unsigned k = 0; k < exp_wr && k < wq.size(); k++)
         check({name, "_wr"}, wq[k],
               {4'h0, 12'((k % DEPTH)), b[HDR_BYTES + 2*k], b[HDR_BYTES + 2*k + 1]});
      check({name, "_done"}, 32'(load_done), 32'(!exp_err));
      check({name, "_err"}, 32'(load_err), 32'(exp_err));
      check({name, "_hold"}, 32'(cpu_hold), 32'(exp_err));
      check({name, "_words"}, 32'(words_loaded), exp_wr);
      check({name, "_ready"}, 32'(in_ready), 0);
      check({name, "_we_gap"}, close_we, 0);
      if (!exp_err) begin
`ifdef LOADER_CHECKSUM_EN
         check({name, "_done_t"}, done_cyc, last_edge);
`else
         if (n == 0) begin
            check({name, "_done_t"}, done_cyc, last_edge);
         end else begin
            check({name, "_we_t"}, last_we_cyc, last_edge);
            check({name, "_done_t"}, done_cyc, last_we_cyc + 1);
         end
`endif
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t f1;
      byte_q_t q;
      int      dummy;
      f1 = add_chk('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 1'b0);

      run_frame("t1", f1, 0);
      run_frame("t2", f1, 45);
      run_frame("t2b", f1, 70);
      run_frame("t3", '{8'h00, 8'h00}, 0);
      run_frame("t4", '{8'h10, 8'h01}, 0);

      // Reset after three bytes, then the full frame
      do_reset();
      q = '{8'h00, 8'h02, 8'h12};
      send(q, 0, dummy);
      mem[0] = 16'h0;
      mem[1] = 16'h0;
      run_frame("t5", f1, 20);
      check("t5_mem0", 32'(mem[0]), 32'h1234);
      check("t5_mem1", 32'(mem[1]), 32'hABCD);

`ifdef LOADER_CHECKSUM_EN
      run_frame("t6_ok", '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'hFE}, 0);
      mem[0] = 16'h0;
      run_frame("t6_bad", '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'h00}, 30);
      check("t6_mem0", 32'(mem[0]), 32'h5AA5);
      run_frame("rnd_bad", mk_frame($urandom_range(12, 1), 1'b1), 25);
`endif

      for (int r = 0; r < 8; r++)
         run_frame("rnd", mk_frame($urandom_range(20, 1), 1'b0), $urandom_range(50));

      run_frame("full", mk_frame(DEPTH, 1'b0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
